// File: rtl/latchnr_bank_ctrl.sv
// latchnr_bank_ctrl: write scheduler for a bank of negative-level latch words.
//
// Round-robin arbitration among NUM_REQ requesters onto one shared latch data bus.
// Each write runs SETUP (data stable, gate closed), OPEN (one gate low) and HOLD
// (gate closed, data held) phases, so at most one entry is ever transparent.
// A bank clear pulses every latch reset for OPEN_CYC cycles.
//
// Ports:
//   C         clock, rising edge
//   R         synchronous active-high reset (does not touch latch contents)
//   REQ       per-requester write request, level, held until GNT
//   ADDR      packed target entries, requester i at [i*AW +: AW]
//   WDATA     packed write data, requester i at [i*DW +: DW]
//   CLR       bank clear request, level, held until CLR_DONE
//   GNT       one-cycle completion pulse to the served requester
//   ERR       pulses with GNT when the served address is >= ENTRIES
//   CLR_DONE  one-cycle pulse when the clear completes
//   BUSY      high whenever the scheduler is not idle
//   VALID     per-entry written flag (only with LATCHNR_BANK_CTRL_VALID_EN)
//   LATCH_D   shared latch data bus
//   LATCH_G   per-entry gate, active-low
//   LATCH_R   per-entry latch reset, active-high
//
// Optional feature macro: LATCHNR_BANK_CTRL_VALID_EN adds the VALID output.
// All outputs are registered.
module latchnr_bank_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                  C,
  input  logic                  R,
  input  logic [NUM_REQ-1:0]    REQ,
  input  logic [NUM_REQ*AW-1:0] ADDR,
  input  logic [NUM_REQ*DW-1:0] WDATA,
  input  logic                  CLR,
  output logic [NUM_REQ-1:0]    GNT,
  output logic                  ERR,
  output logic                  CLR_DONE,
  output logic                  BUSY,
`ifdef LATCHNR_BANK_CTRL_VALID_EN
  output logic [ENTRIES-1:0]    VALID,
`endif
  output logic [DW-1:0]         LATCH_D,
  output logic [ENTRIES-1:0]    LATCH_G,
  output logic [ENTRIES-1:0]    LATCH_R
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StOpen, StHold, StClear} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                err_q, err_d;
  logic                clr_done_q, clr_done_d;
  logic                busy_q, busy_d;
  logic [ENTRIES-1:0]  gate_q, gate_d;
  logic [ENTRIES-1:0]  lrst_q, lrst_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;

  logic [NUM_REQ-1:0]  req_m;
  logic                found;
  logic [PW-1:0]       pick;
  int unsigned         idx;
  logic                addr_err;

  // The requester being acknowledged this cycle is ignored so a held REQ is not re-served.
  assign req_m    = REQ & ~gnt_q;
  assign addr_err = (32'(addr_q) >= ENTRIES);

  // Round-robin: lowest index at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + unsigned'(i)) % NUM_REQ;
      if (!found && req_m[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    gnt_d      = '0;
    err_d      = 1'b0;
    clr_done_d = 1'b0;
    valid_d    = valid_q;

    unique case (state_q)
      StIdle: begin
        // CLR is masked in the CLR_DONE cycle so a still-high level does not re-trigger.
        if (CLR && !clr_done_q) begin
          state_d = StClear;
          cnt_d   = 8'd0;
        end else if (found) begin
          state_d = StSetup;
          cnt_d   = 8'd0;
          gidx_d  = pick;
          addr_d  = ADDR[32'(pick)*AW +: AW];
          data_d  = WDATA[32'(pick)*DW +: DW];
        end
      end
      StSetup: begin
        if (cnt_q == 8'(SETUP_CYC - 1)) begin
          state_d = StOpen;
          cnt_d   = 8'd0;
        end
      end
      StOpen: begin
        if (cnt_q == 8'(OPEN_CYC - 1)) begin
          state_d = StHold;
          cnt_d   = 8'd0;
        end
      end
      StHold: begin
        if (cnt_q == 8'(HOLD_CYC - 1)) begin
          state_d        = StIdle;
          cnt_d          = 8'd0;
          gnt_d[gidx_q]  = 1'b1;
          err_d          = addr_err;
          ptr_d          = (32'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + PW'(1);
          for (int e = 0; e < ENTRIES; e++) begin
            if (!addr_err && 32'(addr_q) == unsigned'(e)) valid_d[e] = 1'b1;
          end
        end
      end
      StClear: begin
        if (cnt_q == 8'(OPEN_CYC - 1)) begin
          state_d    = StIdle;
          cnt_d      = 8'd0;
          clr_done_d = 1'b1;
          valid_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    gate_d = '1;
    lrst_d = '0;
    busy_d = (state_d != StIdle);
    if (state_d == StOpen) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (32'(addr_d) == unsigned'(e)) gate_d[e] = 1'b0;
      end
    end
    if (state_d == StClear) lrst_d = '1;
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      gate_q     <= '1;
      lrst_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      gate_q     <= gate_d;
      lrst_q     <= lrst_d;
      valid_q    <= valid_d;
    end
  end

  assign GNT      = gnt_q;
  assign ERR      = err_q;
  assign CLR_DONE = clr_done_q;
  assign BUSY     = busy_q;
  assign LATCH_D  = data_q;
  assign LATCH_G  = gate_q;
  assign LATCH_R  = lrst_q;

`ifdef LATCHNR_BANK_CTRL_VALID_EN
  assign VALID = valid_q;
`else
  logic unused_valid;
  assign unused_valid = ^valid_q;
`endif

endmodule

// File: tb/tb_latchnr_bank_ctrl.sv
// Directed bench for latchnr_bank_ctrl: three instances cover the default
// configuration, ENTRIES=6 (out-of-range address), and 3/2/2 phase timing.
module tb_latchnr_bank_ctrl;

  logic C = 1'b0;
  logic R = 1'b1;

  always #5 C = ~C;

  // Instance A: defaults
  logic [3:0]  a_req = '0;
  logic [11:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_clr = 1'b0;
  logic [3:0]  a_gnt;
  logic        a_err, a_clr_done, a_busy;
  logic [7:0]  a_ld, a_lg, a_lr;

  // Instance B: ENTRIES=6
  logic [3:0]  b_req = '0;
  logic [11:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_clr = 1'b0;
  logic [3:0]  b_gnt;
  logic        b_err, b_clr_done, b_busy;
  logic [7:0]  b_ld;
  logic [5:0]  b_lg, b_lr;

  // Instance C: SETUP=3, OPEN=2, HOLD=2
  logic [3:0]  c_req = '0;
  logic [11:0] c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_clr = 1'b0;
  logic [3:0]  c_gnt;
  logic        c_err, c_clr_done, c_busy;
  logic [7:0]  c_ld, c_lg, c_lr;

  latchnr_bank_ctrl dut_a (
    .C(C), .R(R), .REQ(a_req), .ADDR(a_addr), .WDATA(a_wdata), .CLR(a_clr),
    .GNT(a_gnt), .ERR(a_err), .CLR_DONE(a_clr_done), .BUSY(a_busy),
    .LATCH_D(a_ld), .LATCH_G(a_lg), .LATCH_R(a_lr)
  );

  latchnr_bank_ctrl #(.ENTRIES(6)) dut_b (
    .C(C), .R(R), .REQ(b_req), .ADDR(b_addr), .WDATA(b_wdata), .CLR(b_clr),
    .GNT(b_gnt), .ERR(b_err), .CLR_DONE(b_clr_done), .BUSY(b_busy),
    .LATCH_D(b_ld), .LATCH_G(b_lg), .LATCH_R(b_lr)
  );

  latchnr_bank_ctrl #(.SETUP_CYC(3), .OPEN_CYC(2), .HOLD_CYC(2)) dut_c (
    .C(C), .R(R), .REQ(c_req), .ADDR(c_addr), .WDATA(c_wdata), .CLR(c_clr),
    .GNT(c_gnt), .ERR(c_err), .CLR_DONE(c_clr_done), .BUSY(c_busy),
    .LATCH_D(c_ld), .LATCH_G(c_lg), .LATCH_R(c_lr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_gnt", 32'(a_gnt), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_clr_done", 32'(a_clr_done), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_ld", 32'(a_ld), 32'h0);
    check("rst_lg", 32'(a_lg), 32'hFF);
    check("rst_lr", 32'(a_lr), 32'h0);

    // Single write: requester 2, entry 5, data A5
    a_req = 4'b0100;
    a_addr[8:6] = 3'd5;
    a_wdata[23:16] = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("w1_ld_c%0d", k), 32'(a_ld), 32'hA5);
      check($sformatf("w1_lg_c%0d", k), 32'(a_lg), (k == 2) ? 32'hDF : 32'hFF);
      check($sformatf("w1_gnt_c%0d", k), 32'(a_gnt), (k == 4) ? 32'h4 : 32'h0);
      check($sformatf("w1_busy_c%0d", k), 32'(a_busy), (k == 4) ? 32'h0 : 32'h1);
    end
    a_req = 4'b0000;
    a_wdata[23:16] = 8'h00;
    tick();
    check("w1_idle_busy", 32'(a_busy), 32'h0);
    check("w1_idle_gnt", 32'(a_gnt), 32'h0);

    // Round robin with all requests held from pointer 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_addr[i*3 +: 3] = 3'(i);
      a_wdata[i*8 +: 8] = 8'h10 + 8'(i);
    end
    a_req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      int r;
      tick();
      r = ((k - 1) / 4) % 4;
      check($sformatf("rr_gnt_c%0d", k), 32'(a_gnt),
            (k % 4 == 0) ? (32'h1 << r) : 32'h0);
      check($sformatf("rr_lg_c%0d", k), 32'(a_lg),
            (k % 4 == 2) ? (32'hFF & ~(32'h1 << r)) : 32'hFF);
      if (k % 4 == 1) check($sformatf("rr_ld_c%0d", k), 32'(a_ld), 32'h10 + 32'(r));
    end
    a_req = 4'b0000;
    tick();
    check("rr_drain_busy", 32'(a_busy), 32'h0);

    // Clear has priority over a simultaneous request
    a_clr = 1'b1;
    a_req = 4'b0001;
    a_addr[2:0] = 3'd1;
    a_wdata[7:0] = 8'h3C;
    tick();
    check("clr_lr", 32'(a_lr), 32'hFF);
    check("clr_lg", 32'(a_lg), 32'hFF);
    check("clr_busy", 32'(a_busy), 32'h1);
    tick();
    check("clr_done", 32'(a_clr_done), 32'h1);
    check("clr_lr_off", 32'(a_lr), 32'h0);
    check("clr_done_busy", 32'(a_busy), 32'h0);
    a_clr = 1'b0;
    tick();
    check("clr_then_ld", 32'(a_ld), 32'h3C);
    check("clr_then_busy", 32'(a_busy), 32'h1);
    check("clr_done_once", 32'(a_clr_done), 32'h0);
    tick();
    check("clr_then_lg", 32'(a_lg), 32'hFD);
    tick();
    tick();
    check("clr_then_gnt", 32'(a_gnt), 32'h1);
    a_req = 4'b0000;
    tick();

    // Out-of-range address on ENTRIES=6 instance
    b_req = 4'b0010;
    b_addr[5:3] = 3'd7;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("oor_lg_c%0d", k), 32'(b_lg), 32'h3F);
      check($sformatf("oor_gnt_c%0d", k), 32'(b_gnt), (k == 4) ? 32'h2 : 32'h0);
      check($sformatf("oor_err_c%0d", k), 32'(b_err), (k == 4) ? 32'h1 : 32'h0);
    end
    // Pointer now 2: with REQ 0,1,3 pending, requester 3 wins
    b_req = 4'b1011;
    b_addr = '0;
    b_addr[2:0] = 3'd0;
    b_addr[5:3] = 3'd1;
    b_addr[11:9] = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) check("ptr_lg", 32'(b_lg), 32'h3B);
    end
    check("ptr_gnt", 32'(b_gnt), 32'h8);
    check("ptr_err", 32'(b_err), 32'h0);
    b_req = 4'b0000;
    tick();

    // Reset mid-write during OPEN
    a_req = 4'b1000;
    a_addr[11:9] = 3'd4;
    a_wdata[31:24] = 8'h77;
    tick();
    tick();
    check("rmid_open_lg", 32'(a_lg), 32'hEF);
    R = 1'b1;
    tick();
    R = 1'b0;
    check("rmid_lg", 32'(a_lg), 32'hFF);
    check("rmid_busy", 32'(a_busy), 32'h0);
    check("rmid_gnt", 32'(a_gnt), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rmid_gnt_c%0d", k), 32'(a_gnt), (k == 4) ? 32'h8 : 32'h0);
    end
    a_req = 4'b0000;
    tick();

    // Longer phases: 3/2/2
    c_req = 4'b0001;
    c_addr[2:0] = 3'd3;
    c_wdata[7:0] = 8'h5A;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("tim_lg_c%0d", k), 32'(c_lg), (k == 4 || k == 5) ? 32'hF7 : 32'hFF);
      check($sformatf("tim_gnt_c%0d", k), 32'(c_gnt), (k == 8) ? 32'h1 : 32'h0);
    end
    check("tim_ld", 32'(c_ld), 32'h5A);
    c_req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/latchnr_bank_ctrl.md
Name: latchnr_bank_ctrl

Overview:
Write scheduler for a bank of ENTRIES negative-level latch words (DW bits each; gate active-low, reset active-high).
- Round-robin arbitration among NUM_REQ write requesters; one shared latch data bus.
- Per-entry gate timing: setup before the gate opens, open window, hold after it closes. No two entries are ever open at once.
- Bank-wide clear via the latch reset inputs.
- Sits between fabric-side requesters and the latch bank in the primitive models library.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- ENTRIES, 8, number of latch words (1..2**AW)
- DW, 8, latch word width
- AW, 3, address width per requester
- SETUP_CYC, 1, cycles LATCH_D is stable before the gate opens (1..255)
- OPEN_CYC, 1, cycles the gate is low; also the clear pulse length (1..255)
- HOLD_CYC, 1, cycles LATCH_D is held after the gate closes (1..255)

Ports:
- C  input  1  clock, rising edge
- R  input  1  synchronous active-high reset
- REQ  input  NUM_REQ  write request per requester; level, held until GNT
- ADDR  input  NUM_REQ*AW  target entry; requester i uses bits [i*AW +: AW]
- WDATA  input  NUM_REQ*DW  write data; requester i uses bits [i*DW +: DW]
- CLR  input  1  bank clear request; level, held until CLR_DONE
- GNT  output  NUM_REQ  one-cycle completion pulse to the served requester
- ERR  output  1  one-cycle pulse with GNT when the served address is >= ENTRIES
- CLR_DONE  output  1  one-cycle pulse when the clear completes
- BUSY  output  1  high whenever the state is not IDLE
- LATCH_D  output  DW  shared data bus to all latch D inputs
- LATCH_G  output  ENTRIES  per-entry gate, active-low (1 = opaque)
- LATCH_R  output  ENTRIES  per-entry latch reset, active-high

Behaviour:
Reset values (sampled on rising C while R=1, at any point mid-operation):
- State IDLE; counter 0; RR pointer 0; captured addr/data 0.
- GNT=0, ERR=0, CLR_DONE=0, BUSY=0, LATCH_D=0, LATCH_G=all 1, LATCH_R=all 0.
- Latch contents are not disturbed by controller reset.
- An in-flight write is abandoned: no GNT, and LATCH_G is forced to 1 on the next edge.

All outputs are registered.

States: IDLE, SETUP, OPEN, HOLD, CLEAR.

IDLE:
- If CLR=1: go to CLEAR. CLR has priority over all REQ.
- Else if any unmasked REQ: grant the lowest index >= pointer, wrapping modulo NUM_REQ.
  - Capture that requester's ADDR and WDATA.
  - LATCH_D <= captured WDATA.
  - Go to SETUP.
- Mask: in the cycle GNT[i] is high, REQ[i] is ignored.

SETUP: stays SETUP_CYC cycles, then OPEN.

OPEN:
- For OPEN_CYC cycles, LATCH_G[addr]=0. All other gate bits stay 1.
- If addr >= ENTRIES, no gate bit falls.

HOLD:
- For HOLD_CYC cycles, LATCH_G is all 1 and LATCH_D is unchanged.
- Then go to IDLE with GNT[granted]=1 for exactly one cycle, ERR set if addr >= ENTRIES, and pointer <= (granted+1) mod NUM_REQ.

CLEAR:
- For OPEN_CYC cycles, LATCH_R is all 1 and LATCH_G is all 1.
- Then go to IDLE with CLR_DONE=1 for one cycle.
- CLR is masked during the CLR_DONE cycle.

Timing and data rules:
- Write latency, REQ seen to GNT high = 1 + SETUP_CYC + OPEN_CYC + HOLD_CYC cycles (4 with defaults).
- Back-to-back throughput: a new grant can be taken in the GNT cycle.
- LATCH_D changes only on the IDLE to SETUP capture edge. Requester ADDR/WDATA changes after capture have no effect.
- A requester that drops REQ before GNT still completes its write.
- CLR asserted mid-write is served only after the current write's GNT.
- The phase counter is 8 bits and reloads on every state entry.

Optional Feature:
Macro LATCHNR_BANK_CTRL_VALID_EN.
- Defined: adds output VALID [ENTRIES], reset 0.
  - VALID[addr] is set on the GNT edge of a non-ERR write.
  - All VALID bits are cleared on the CLR_DONE edge.
- Undefined: no VALID port, no extra logic.

Test Plan:
- Reset, then REQ[2]=1, ADDR2=5, WDATA2=0xA5: LATCH_D=0xA5 from cycle 1; LATCH_G[5]=0 in cycle 2 only; GNT[2]=1 in cycle 4; all other gate bits stay 1.
- REQ=4'b1111 held, defaults: GNT order 0,1,2,3,0; period 4 cycles; gate lows never overlap.
- CLR=1 together with REQ[0]=1 in IDLE: LATCH_R=all 1 for 1 cycle, then CLR_DONE; the REQ[0] write starts the following cycle.
- ADDR1=7 with ENTRIES=6: no LATCH_G bit falls; GNT[1] and ERR pulse together; pointer advances to 2.
- R=1 during OPEN: next edge gives LATCH_G=all 1, BUSY=0, no GNT; after R=0, REQ[3] is served first with pointer at 0 (REQ[0..2]=0).
- SETUP_CYC=3, OPEN_CYC=2, HOLD_CYC=2: GNT arrives 8 cycles after REQ; the gate is low for exactly 2 cycles.
